// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address/word widths, loader state encoding and the
// largest program the instruction memory can hold.
package cpu_pkg;

  localparam int unsigned D         = 12;
  localparam int unsigned W         = 9;
  localparam int unsigned MAX_WORDS = 2 ** D;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_INS_LO,
    S_INS_HI,
    S_CHK,
    S_RUN,
    S_ERR
  } load_state_t;

endpackage

// File: rtl/prog_loader.sv
// Instruction-memory writer: parses a framed host byte stream into 9-bit words,
// writes them from address 0, and releases the CPU only after a good checksum.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int unsigned D = 12,
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         rx_ready,
  output logic         im_wr_en,
  output logic [D-1:0] im_wr_addr,
  output logic [W-1:0] im_wr_data,
  output logic         start,
  output logic         busy,
  output logic         load_ok,
  output logic         load_err
);

  localparam logic [16:0] MAX_N = 17'(2 ** D);

  load_state_t  state;
  logic [7:0]   len_lo;
  logic [7:0]   ins_lo;
  logic [7:0]   acc;
  logic [15:0]  n_words;
  logic [D:0]   cnt;
  logic [D:0]   cnt_nxt;
  logic [15:0]  n_rx;
  logic         last_word;
  logic         take;

  always_comb begin
    rx_ready = 1'b0;
    if (!reset) begin
      unique case (state)
        S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI, S_CHK: rx_ready = 1'b1;
        default:                                       rx_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    take      = rx_valid && rx_ready;
    n_rx      = {rx_data, len_lo};
    cnt_nxt   = cnt + 1'b1;
    last_word = (17'(cnt_nxt) == {1'b0, n_words});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LEN_LO;
      len_lo     <= '0;
      ins_lo     <= '0;
      acc        <= '0;
      n_words    <= '0;
      cnt        <= '0;
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
      start      <= 1'b1;
      busy       <= 1'b0;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      im_wr_en <= 1'b0;
      if (take) begin
        unique case (state)
          S_LEN_LO: begin
            len_lo <= rx_data;
            acc    <= acc ^ rx_data;
            busy   <= 1'b1;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            acc     <= acc ^ rx_data;
            n_words <= n_rx;
            if ({1'b0, n_rx} > MAX_N) begin
              state    <= S_ERR;
              load_err <= 1'b1;
              busy     <= 1'b0;
            end else if (n_rx == 16'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_INS_LO;
            end
          end
          S_INS_LO: begin
            ins_lo <= rx_data;
            acc    <= acc ^ rx_data;
            state  <= S_INS_HI;
          end
          S_INS_HI: begin
            if (|rx_data[7:1]) begin
              state    <= S_ERR;
              load_err <= 1'b1;
              busy     <= 1'b0;
            end else begin
              im_wr_en   <= 1'b1;
              im_wr_addr <= cnt[D-1:0];
              im_wr_data <= W'({rx_data[0], ins_lo});
              acc        <= acc ^ rx_data;
              cnt        <= cnt_nxt;
              state      <= last_word ? S_CHK : S_INS_LO;
            end
          end
          S_CHK: begin
            busy <= 1'b0;
            if (rx_data == acc) begin
              state   <= S_RUN;
              start   <= 1'b0;
              load_ok <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level reference model predicts the
// memory writes and final status; a monitor checks every write strobe.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        im_wr_en;
  logic [11:0] im_wr_addr;
  logic [8:0]  im_wr_data;
  logic        start;
  logic        busy;
  logic        load_ok;
  logic        load_err;

  int total = 0;
  int bad = 0;
  int last_addr = -1;
  logic [20:0] exp_q[$];
  logic [7:0]  fr[$];

  always #5 clk = ~clk;

  prog_loader #(.D(12), .W(9)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr),
    .im_wr_data(im_wr_data), .start(start), .busy(busy),
    .load_ok(load_ok), .load_err(load_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (im_wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected none",
                 im_wr_addr, im_wr_data);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({im_wr_addr, im_wr_data} !== e) begin
          bad++;
          $display("FAIL write: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                   im_wr_addr, im_wr_data, e[20:9], e[8:0]);
        end
      end
      last_addr = int'(im_wr_addr);
    end
  end

  // Reference model: interprets the whole frame by its byte-level rules.
  task automatic model(output int consumed, output bit ok);
    int n;
    logic [7:0] x;
    n = int'(fr[0]) + 256 * int'(fr[1]);
    ok = 1'b0;
    if (n > 4096) begin
      consumed = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (fr[3 + 2 * i] > 8'd1) begin
        consumed = 4 + 2 * i;
        return;
      end
      exp_q.push_back({12'(i), fr[3 + 2 * i][0], fr[2 + 2 * i]});
    end
    x = '0;
    for (int i = 0; i < 2 + 2 * n; i++) x ^= fr[i];
    consumed = 3 + 2 * n;
    ok = (fr[2 + 2 * n] == x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rx_ready_in_reset", 32'(rx_ready), 32'd0);
    check("rst_wr_en", 32'(im_wr_en), 32'd0);
    check("rst_addr", 32'(im_wr_addr), 32'd0);
    check("rst_data", 32'(im_wr_data), 32'd0);
    check("rst_start", 32'(start), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ok", 32'(load_ok), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    reset = 1'b0;
    #1;
    check("rx_ready_after_reset", 32'(rx_ready), 32'd1);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int unsigned waited = 0;
    ok = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (rx_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    ok = 1'b1;
  endtask

  task automatic gap(input bit gaps_en);
    if (gaps_en && $urandom_range(2) == 0) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
  endtask

  task automatic run_frame(input bit gaps_en);
    int consumed;
    bit good;
    bit ok;
    model(consumed, good);
    for (int i = 0; i < consumed; i++) begin
      if (good && i == consumed - 1) check("start_hold_before_chk", 32'(start), 32'd1);
      send_byte(fr[i], ok);
      if (!ok) break;
      if (i == 0) check("busy_in_frame", 32'(busy), 32'd1);
      if (good && i == consumed - 1) check("start_fall", 32'(start), 32'd0);
      if (i != consumed - 1) gap(gaps_en);
    end
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("load_ok", 32'(load_ok), 32'(good));
    check("load_err", 32'(load_err), 32'(!good));
    check("start_end", 32'(start), 32'(!good));
    check("busy_end", 32'(busy), 32'd0);
    check("rx_ready_end", 32'(rx_ready), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_frame1(input logic [7:0] chk);
    fr = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01, chk};
  endtask

  initial begin
    bit ok;
    do_reset();

    load_frame1(8'hDA);
    run_frame(1'b0);

    do_reset();
    load_frame1(8'hDB);
    run_frame(1'b0);

    do_reset();
    fr = '{8'h01, 8'h00, 8'h55, 8'h02, 8'h00};
    run_frame(1'b0);

    do_reset();
    fr = '{8'h00, 8'h00, 8'h00};
    run_frame(1'b0);

    do_reset();
    fr = '{8'h01, 8'h10, 8'h00};
    run_frame(1'b0);

    do_reset();
    fr = '{8'h00, 8'h10};
    for (int i = 0; i < 4096; i++) begin
      fr.push_back(8'($urandom));
      fr.push_back(8'($urandom_range(1)));
    end
    begin
      logic [7:0] x = '0;
      foreach (fr[i]) x ^= fr[i];
      fr.push_back(x);
    end
    last_addr = -1;
    run_frame(1'b0);
    check("full_last_addr", 32'(last_addr), 32'h0FFF);

    // Abort after two words, then a clean reload must start again at address 0.
    do_reset();
    load_frame1(8'hDA);
    exp_q.push_back({12'd0, 9'h112});
    exp_q.push_back({12'd1, 9'h034});
    for (int i = 0; i < 6; i++) begin
      send_byte(fr[i], ok);
      gap(1'b1);
    end
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("partial_writes", 32'(exp_q.size()), 32'd0);
    do_reset();
    run_frame(1'b1);

    for (int t = 0; t < 24; t++) begin
      int n;
      int bad_hi;
      logic [7:0] x;
      do_reset();
      n = $urandom_range(6);
      bad_hi = ($urandom_range(5) == 0 && n > 0) ? $urandom_range(n - 1) : -1;
      fr = '{8'(n), 8'h00};
      for (int i = 0; i < n; i++) begin
        fr.push_back(8'($urandom));
        if (i == bad_hi) fr.push_back(8'($urandom_range(255, 2)));
        else fr.push_back(8'($urandom_range(1)));
      end
      x = '0;
      foreach (fr[i]) x ^= fr[i];
      if ($urandom_range(3) == 0) x ^= 8'($urandom_range(255, 1));
      fr.push_back(x);
      run_frame(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
